// File: rtl/bcd_entry_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_entry_encoder
//  Purpose  : Two-digit decimal keypad entry (tens digit first, then units
//             digit) converted to a 4-bit binary value 0..15. The digits
//             entered are echoed on two 7-segment displays.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1  system clock, rising edge
//    rst_n     in   1  synchronous active-low reset
//    digit_in  in   4  BCD digit from switches
//    enter     in   1  strobe, latches digit_in (one strobe per high cycle)
//    clear     in   1  strobe, aborts entry / clears error (beats enter)
//    bin_out   out  4  registered binary result
//    valid     out  1  one-cycle pulse marking a new bin_out
//    error     out  1  high while in the error state
//    busy      out  1  high while waiting for the units digit
//    display1  out  7  tens echo, active-high segments, bit0=A .. bit6=G
//    display2  out  7  units echo, same encoding
// ============================================================================
module bcd_entry_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       enter,
  input  logic       clear,
  output logic [3:0] bin_out,
  output logic       valid,
  output logic       error,
  output logic       busy,
  output logic [6:0] display1,
  output logic [6:0] display2
);

  typedef enum logic [1:0] {
    S_TENS  = 2'd0,
    S_UNITS = 2'd1,
    S_SHOW  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [6:0] C_SEG_BLANK = 7'b0000000;
  localparam logic [6:0] C_SEG_DASH  = 7'b1000000;

  state_t     state_q, state_d;
  logic [3:0] tens_q,  tens_d;
  logic [3:0] units_q, units_d;
  logic [3:0] bin_q,   bin_d;
  logic       valid_q, valid_d;
  logic [6:0] disp1_q, disp1_d;
  logic [6:0] disp2_q, disp2_d;
  logic [4:0] value_w;

  // Digit to segment pattern; codes above 9 never reach a display but
  // decode to blank for completeness.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = C_SEG_BLANK;
    endcase
  endfunction

  // tens*10 + units as shift-and-add; 5 bits holds the worst case 1*10+9.
  assign value_w = ({1'b0, tens_q} << 3) + ({1'b0, tens_q} << 1) + {1'b0, digit_in};

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    bin_d   = bin_q;
    valid_d = 1'b0;
    disp1_d = C_SEG_BLANK;
    disp2_d = C_SEG_BLANK;

    if (clear) begin
      // clear wins over a simultaneous enter, so digit_in is not latched
      state_d = S_TENS;
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (enter) begin
      case (state_q)
        S_TENS, S_SHOW: begin
          if (digit_in <= 4'd1) begin
            tens_d  = digit_in;
            units_d = 4'd0;
            state_d = S_UNITS;
          end else begin
            state_d = S_ERR;
          end
        end
        S_UNITS: begin
          if (digit_in > 4'd9 || value_w > 5'd15) begin
            state_d = S_ERR;
          end else begin
            units_d = digit_in;
            bin_d   = value_w[3:0];
            valid_d = 1'b1;
            state_d = S_SHOW;
          end
        end
        default: ; // S_ERR ignores enter
      endcase
    end

    // Displays are decoded from the next state so they change on the same
    // edge as the state register.
    case (state_d)
      S_UNITS: disp1_d = seg7(tens_d);
      S_SHOW: begin
        disp1_d = seg7(tens_d);
        disp2_d = seg7(units_d);
      end
      S_ERR: begin
        disp1_d = C_SEG_DASH;
        disp2_d = C_SEG_DASH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_TENS;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      bin_q   <= 4'd0;
      valid_q <= 1'b0;
      disp1_q <= C_SEG_BLANK;
      disp2_q <= C_SEG_BLANK;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      disp1_q <= disp1_d;
      disp2_q <= disp2_d;
    end
  end

  assign bin_out  = bin_q;
  assign valid    = valid_q;
  assign error    = (state_q == S_ERR);
  assign busy     = (state_q == S_UNITS);
  assign display1 = disp1_q;
  assign display2 = disp2_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_entry_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_entry_encoder
//  Purpose  : Directed self-checking bench for bcd_entry_encoder. Inputs are
//             driven on the falling edge, outputs compared on the next
//             falling edge as one packed snapshot.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_entry_encoder;

  localparam logic [6:0] C_BL = 7'h00;
  localparam logic [6:0] C_DA = 7'h40;
  localparam logic [6:0] C_S0 = 7'h3F;
  localparam logic [6:0] C_S1 = 7'h06;
  localparam logic [6:0] C_S3 = 7'h4F;
  localparam logic [6:0] C_S5 = 7'h6D;
  localparam logic [6:0] C_S7 = 7'h07;
  localparam logic [6:0] C_S9 = 7'h6F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] bin_out;
  logic       valid, error, busy;
  logic [6:0] display1, display2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_entry_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digit_in (digit_in),
    .enter    (enter),
    .clear    (clear),
    .bin_out  (bin_out),
    .valid    (valid),
    .error    (error),
    .busy     (busy),
    .display1 (display1),
    .display2 (display2)
  );

  // Snapshot layout: {bin_out, valid, error, busy, display1, display2}
  logic [20:0] obs;
  assign obs = {bin_out, valid, error, busy, display1, display2};

  function automatic logic [20:0] pack(input logic [3:0] b, input logic v, input logic e,
                                       input logic bz, input logic [6:0] d1, input logic [6:0] d2);
    pack = {b, v, e, bz, d1, d2};
  endfunction

  // Stimulus helpers: called at a falling edge, return one clock later.
  task automatic do_enter(input logic [3:0] d);
    digit_in = d;
    enter    = 1'b1;
    @(negedge clk);
    enter    = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] exp;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp = pack(4'd0, 0, 0, 0, C_BL, C_BL);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset: got %h expected %h", obs, exp); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_13();
    logic [20:0] exp;
    do_enter(4'd1);
    exp = pack(4'd0, 0, 0, 1, C_S1, C_BL);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL basic_tens: got %h expected %h", obs, exp); end
    do_enter(4'd3);
    exp = pack(4'd13, 1, 0, 0, C_S1, C_S3);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL basic_units: got %h expected %h", obs, exp); end
    @(negedge clk);
    exp = pack(4'd13, 0, 0, 0, C_S1, C_S3);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL basic_hold: got %h expected %h", obs, exp); end
  endtask

  task automatic test_seven();
    logic [20:0] exp;
    do_enter(4'd0);
    exp = pack(4'd13, 0, 0, 1, C_S0, C_BL);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL seven_tens: got %h expected %h", obs, exp); end
    do_enter(4'd7);
    exp = pack(4'd7, 1, 0, 0, C_S0, C_S7);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL seven_units: got %h expected %h", obs, exp); end
    @(negedge clk);
    exp = pack(4'd7, 0, 0, 0, C_S0, C_S7);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL seven_single_pulse: got %h expected %h", obs, exp); end
    do_enter(4'd1);
    exp = pack(4'd7, 0, 0, 1, C_S1, C_BL);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL seven_reenter: got %h expected %h", obs, exp); end
  endtask

  // Continues from S_UNITS with tens=1.
  task automatic test_overflow();
    logic [20:0] exp;
    do_enter(4'd6);
    exp = pack(4'd7, 0, 1, 0, C_DA, C_DA);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL overflow_err: got %h expected %h", obs, exp); end
    do_clear();
    exp = pack(4'd7, 0, 0, 0, C_BL, C_BL);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL overflow_clear: got %h expected %h", obs, exp); end
    do_enter(4'd0);
    do_enter(4'd10);
    exp = pack(4'd7, 0, 1, 0, C_DA, C_DA);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL units_not_bcd: got %h expected %h", obs, exp); end
    do_clear();
  endtask

  task automatic test_bad_tens();
    logic [20:0] exp;
    do_enter(4'd2);
    exp = pack(4'd7, 0, 1, 0, C_DA, C_DA);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL bad_tens: got %h expected %h", obs, exp); end
    do_enter(4'd0);
    do_enter(4'd1);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL err_ignores_enter: got %h expected %h", obs, exp); end
    do_clear();
    do_enter(4'd1);
    exp = pack(4'd7, 0, 0, 1, C_S1, C_BL);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL after_err_clear: got %h expected %h", obs, exp); end
  endtask

  // Continues from S_UNITS with tens=1.
  task automatic test_clear_priority();
    logic [20:0] exp;
    digit_in = 4'd5;
    enter    = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    enter    = 1'b0;
    clear    = 1'b0;
    exp = pack(4'd7, 0, 0, 0, C_BL, C_BL);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL clear_beats_enter: got %h expected %h", obs, exp); end
    do_enter(4'd0);
    do_enter(4'd9);
    exp = pack(4'd9, 1, 0, 0, C_S0, C_S9);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL value_09: got %h expected %h", obs, exp); end
    do_enter(4'd1);
    do_enter(4'd5);
    exp = pack(4'd15, 1, 0, 0, C_S1, C_S5);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL value_15: got %h expected %h", obs, exp); end
  endtask

  // Continues from S_SHOW with 15 displayed; enter held three cycles.
  task automatic test_back_to_back();
    logic [20:0] exp;
    digit_in = 4'd1;
    enter    = 1'b1;
    @(negedge clk);
    exp = pack(4'd15, 0, 0, 1, C_S1, C_BL);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL held_1: got %h expected %h", obs, exp); end
    @(negedge clk);
    exp = pack(4'd11, 1, 0, 0, C_S1, C_S1);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL held_2: got %h expected %h", obs, exp); end
    @(negedge clk);
    enter = 1'b0;
    exp = pack(4'd11, 0, 0, 1, C_S1, C_BL);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL held_3: got %h expected %h", obs, exp); end
  endtask

  // Continues from S_UNITS with tens=1.
  task automatic test_reset_priority();
    logic [20:0] exp;
    rst_n    = 1'b0;
    digit_in = 4'd3;
    enter    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    enter = 1'b0;
    exp = pack(4'd0, 0, 0, 0, C_BL, C_BL);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_in_units: got %h expected %h", obs, exp); end
    do_enter(4'd2);
    rst_n = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    clear = 1'b0;
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_in_err: got %h expected %h", obs, exp); end
    do_enter(4'd1);
    do_enter(4'd2);
    exp = pack(4'd12, 1, 0, 0, C_S1, 7'h5B);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL after_reset_12: got %h expected %h", obs, exp); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_13();
    test_seven();
    test_overflow();
    test_bad_tens();
    test_clear_priority();
    test_back_to_back();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
